bus_burst_ram_slave: RTL
========================

Name: bus_burst_ram_slave

Overview:
- Burst-capable bus slave with internal word memory. Sits directly downstream of the DMA controller on the shared bus.
- Consumes the DMA's begin/address/burst transactions. Returns read beats, or absorbs write beats with busy-driven back-pressure.
- Signals address errors with busError plus endTransaction.
- Used as the DMA's target in simulation and as a fast on-chip scratch memory.

Parameters:
- baseAddress, 32'h50000000, byte address of word 0; must be aligned to 4*2^addressBits.
- addressBits, 10, log2 of memory depth in 32-bit words (default 1024 words).
- readLatency, 2, cycles from the beginTransaction cycle to the first read beat; legal range 1..15.
- busyPeriod, 0, write stall injection: every busyPeriod-th write-state cycle raises busyOut; 0 disables.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- beginTransactionIn  in  1  master starts a transaction; address is on addressDataIn.
- addressDataIn  in  32  address in the begin cycle, write data in beat cycles.
- readNotWriteIn  in  1  valid in the begin cycle; 1 = read.
- burstSizeIn  in  8  valid in the begin cycle; beats minus 1.
- byteEnablesIn  in  4  valid in the begin cycle; applied to every write beat of the burst.
- dataValidIn  in  1  write beat present on addressDataIn.
- endTransactionIn  in  1  master ends a write transaction.
- addressDataOut  out  32  read data; 0 when not driving.
- dataValidOut  out  1  read beat valid.
- endTransactionOut  out  1  slave ends a read or error transaction.
- busErrorOut  out  1  transaction rejected.
- busyOut  out  1  write beat in this cycle is not accepted.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset behaviour:
  - All outputs are 0 after reset and whenever not actively driving (wired-OR bus).
  - State returns to IDLE; burst and beat counters clear.
  - Memory contents are retained.
  - Reset mid-burst: outputs are 0 from the next cycle; the partial burst is abandoned with no endTransactionOut.
- States: IDLE, RD_WAIT, RD_BURST, RD_END, WR_BURST, ERR.
- Begin-cycle capture (IDLE, beginTransactionIn=1):
  - Latch word index = (addr-baseAddress)>>2, beatsLeft = burstSizeIn+1 (9-bit), byte enables, direction.
  - beginTransactionIn outside IDLE is ignored.
- Error check in the begin cycle:
  - An error is raised if addr[1:0]!=0, addr<baseAddress, or the word index + burstSizeIn >= 2^addressBits. This is a 33-bit compare, so there is no wrap-around.
  - On error go to ERR. Next cycle busErrorOut=1 and endTransactionOut=1 together for exactly 1 cycle, then IDLE.
  - No memory access occurs on an errored transaction.
- Read path:
  - RD_WAIT counts readLatency-1 cycles; readLatency=1 goes straight to RD_BURST.
  - RD_BURST: one beat per cycle with no gaps. dataValidOut=1 and addressDataOut = mem[index]; index++, beatsLeft--.
  - First beat appears exactly readLatency cycles after the begin cycle.
  - After the last beat go to RD_END: endTransactionOut=1 for 1 cycle with dataValidOut=0, then IDLE.
  - Memory read is synchronous; address is presented one cycle ahead so the beat data is registered.
- Write path:
  - WR_BURST: a beat is accepted iff dataValidIn=1 and busyOut=0 in the same cycle.
  - Accepted beat: mem[index] bytes written where byteEnables[i]=1 (byte i = bits 8i+7:8i); index++, beatsLeft--.
  - Beats arriving with beatsLeft=0 are dropped.
  - endTransactionIn=1 returns to IDLE next cycle. A beat in that same cycle is still accepted if otherwise legal.
  - Early end (fewer beats than announced) is legal; remaining words are untouched.
  - busyOut: a cycle counter runs in WR_BURST. busyOut=1 when busyPeriod!=0 and counter == busyPeriod-1, then the counter wraps to 0. busyOut is combinational from state and counter.
- Data is stored unmodified; byte swapping is the master's responsibility.
- Simultaneous reset and begin: reset wins.

Test Plan:
- Write then read, contiguous:
  - Stimulus: reset, preload nothing. Write burst at 0x50000010, burstSizeIn=3, BE=4'hF, data 0x11111111..0x44444444. Then read the same range, latency 2.
  - Required: dataValidOut high on cycles begin+2..begin+5 with those 4 values. endTransactionOut on begin+6.
- Byte enables:
  - Stimulus: write 0xAABBCCDD at 0x50000000 with BE=4'hF, then 0x00000000 with BE=4'b0101. Read back.
  - Required: 0xAA00CC00.
- Busy back-pressure:
  - Stimulus: busyPeriod=3, write burst of 8 beats with the master holding data while busy.
  - Required: busyOut high on every 3rd WR_BURST cycle. All 8 words are stored once, in order, with no duplicates.
- Out-of-range:
  - Stimulus: read at 0x50000FFC with burstSizeIn=1 (depth 1024).
  - Required: busErrorOut=endTransactionOut=1 for exactly one cycle, no dataValidOut, then IDLE.
  - Also: misaligned 0x50000002 gives the same response.
- Reset mid-read:
  - Stimulus: 16-beat read, assert reset on beat 5.
  - Required: all outputs 0 the next cycle, no endTransactionOut.
  - A following read returns the correct memory contents.
- Early write end:
  - Stimulus: burstSizeIn=7, endTransactionIn after 3 beats.
  - Required: only 3 words are modified, back in IDLE, and the next begin is accepted.

Source files
------------

// File: rtl/bus_burst_ram_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : bus_burst_ram_slave_if
//  Purpose  : Shared-bus signal bundle between a DMA-style master and the
//             burst RAM slave (begin/address/burst in, beats and status out).
//  Revision : 1.0  initial release
// ============================================================================
interface bus_burst_ram_slave_if;
    logic        beginTransactionIn;
    logic [31:0] addressDataIn;
    logic        readNotWriteIn;
    logic [7:0]  burstSizeIn;
    logic [3:0]  byteEnablesIn;
    logic        dataValidIn;
    logic        endTransactionIn;
    logic [31:0] addressDataOut;
    logic        dataValidOut;
    logic        endTransactionOut;
    logic        busErrorOut;
    logic        busyOut;

    modport slave (
        input  beginTransactionIn, addressDataIn, readNotWriteIn, burstSizeIn,
               byteEnablesIn, dataValidIn, endTransactionIn,
        output addressDataOut, dataValidOut, endTransactionOut, busErrorOut,
               busyOut
    );

    modport master (
        output beginTransactionIn, addressDataIn, readNotWriteIn, burstSizeIn,
               byteEnablesIn, dataValidIn, endTransactionIn,
        input  addressDataOut, dataValidOut, endTransactionOut, busErrorOut,
               busyOut
    );
endinterface
`default_nettype wire

// File: rtl/bus_burst_ram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : bus_burst_ram_slave
//  Purpose  : Burst-capable bus slave backed by a word RAM, with read latency,
//             write back-pressure injection and address error reporting.
//  Revision : 1.0  initial release
// ============================================================================
module bus_burst_ram_slave #(
    parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
    parameter int unsigned ADDRESS_BITS = 10,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned BUSY_PERIOD  = 0
) (
    input  wire logic            clock,
    input  wire logic            reset,
    bus_burst_ram_slave_if.slave bus
);

    localparam int unsigned            c_DEPTH     = 1 << ADDRESS_BITS;
    localparam logic [32:0]            c_DEPTH_33  = 33'(c_DEPTH);
    localparam logic [29:0]            c_BASE_WORD = BASE_ADDRESS[31:2];
    localparam logic [3:0]             c_WAIT_LAST = (READ_LATENCY >= 2) ? 4'(READ_LATENCY - 2) : 4'd0;
    localparam int unsigned            c_BUSY_W    = (BUSY_PERIOD > 2) ? $clog2(BUSY_PERIOD) : 1;
    localparam logic [c_BUSY_W-1:0]    c_BUSY_LAST = (BUSY_PERIOD > 0) ? c_BUSY_W'(BUSY_PERIOD - 1) : '0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_BURST = 3'd2,
        RD_END   = 3'd3,
        WR_BURST = 3'd4,
        ERR      = 3'd5
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;

    logic [31:0]               r_mem [c_DEPTH];
    logic [31:0]               r_rdata;
    logic [ADDRESS_BITS-1:0]   r_index;
    logic [8:0]                r_beats_left;
    logic [3:0]                r_be;
    logic [3:0]                r_wait_cnt;
    logic [c_BUSY_W-1:0]       r_busy_cnt;

    logic                      w_begin;
    logic [29:0]               w_word_off;
    logic [32:0]               w_span_end;
    logic                      w_addr_err;
    logic                      w_busy;
    logic                      w_accept;
    logic [ADDRESS_BITS-1:0]   w_rd_addr;

    // Range check is done on 33 bits so a burst can never wrap past the top.
    assign w_begin    = (r_state == IDLE) && bus.beginTransactionIn;
    assign w_word_off = bus.addressDataIn[31:2] - c_BASE_WORD;
    assign w_span_end = {3'b000, w_word_off} + {25'd0, bus.burstSizeIn};
    assign w_addr_err = (bus.addressDataIn[1:0] != 2'b00)
                     || (bus.addressDataIn < BASE_ADDRESS)
                     || (w_span_end >= c_DEPTH_33);

    assign w_busy   = (BUSY_PERIOD != 0) && (r_state == WR_BURST) && (r_busy_cnt == c_BUSY_LAST);
    assign w_accept = (r_state == WR_BURST) && bus.dataValidIn && !w_busy && (r_beats_left != 9'd0);

    // The RAM is read one cycle ahead of the beat so the beat data is registered.
    always_comb begin
        w_rd_addr = r_index;
        if (r_state == IDLE) begin
            w_rd_addr = w_word_off[ADDRESS_BITS-1:0];
        end else if (r_state == RD_BURST) begin
            w_rd_addr = r_index + ADDRESS_BITS'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next          = r_state;
        bus.addressDataOut    = 32'd0;
        bus.dataValidOut      = 1'b0;
        bus.endTransactionOut = 1'b0;
        bus.busErrorOut       = 1'b0;
        bus.busyOut           = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.beginTransactionIn) begin
                    if (w_addr_err) begin
                        w_state_next = ERR;
                    end else if (!bus.readNotWriteIn) begin
                        w_state_next = WR_BURST;
                    end else if (READ_LATENCY <= 1) begin
                        w_state_next = RD_BURST;
                    end else begin
                        w_state_next = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (r_wait_cnt == c_WAIT_LAST) begin
                    w_state_next = RD_BURST;
                end
            end
            RD_BURST: begin
                bus.dataValidOut   = 1'b1;
                bus.addressDataOut = r_rdata;
                if (r_beats_left == 9'd1) begin
                    w_state_next = RD_END;
                end
            end
            RD_END: begin
                bus.endTransactionOut = 1'b1;
                w_state_next          = IDLE;
            end
            WR_BURST: begin
                bus.busyOut = w_busy;
                if (bus.endTransactionIn) begin
                    w_state_next = IDLE;
                end
            end
            ERR: begin
                bus.busErrorOut       = 1'b1;
                bus.endTransactionOut = 1'b1;
                w_state_next          = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_index      <= '0;
            r_beats_left <= '0;
            r_be         <= '0;
            r_wait_cnt   <= '0;
            r_busy_cnt   <= '0;
        end else if (w_begin) begin
            r_index      <= w_word_off[ADDRESS_BITS-1:0];
            r_beats_left <= {1'b0, bus.burstSizeIn} + 9'd1;
            r_be         <= bus.byteEnablesIn;
            r_wait_cnt   <= '0;
            r_busy_cnt   <= '0;
        end else begin
            case (r_state)
                RD_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                end
                RD_BURST: begin
                    r_index      <= r_index + ADDRESS_BITS'(1);
                    r_beats_left <= r_beats_left - 9'd1;
                end
                WR_BURST: begin
                    r_busy_cnt <= (r_busy_cnt == c_BUSY_LAST) ? '0 : r_busy_cnt + c_BUSY_W'(1);
                    if (w_accept) begin
                        r_index      <= r_index + ADDRESS_BITS'(1);
                        r_beats_left <= r_beats_left - 9'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Memory contents survive reset; only the write strobe is qualified by it.
    always_ff @(posedge clock) begin
        r_rdata <= r_mem[w_rd_addr];
        if (w_accept && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (r_be[b]) begin
                    r_mem[r_index][8*b +: 8] <= bus.addressDataIn[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
